// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: IRAM read port, decode-side instruction port and PC redirect inputs.
// master = fetch unit, slave = environment (IRAM + decode/ALU).
interface ifu_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            iram_rd_en_o;
  logic [XLEN-1:0] iram_rd_addr_o;
  logic            iram_rd_valid_i;
  logic [XLEN-1:0] iram_rd_data_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [XLEN-1:0] inst_data_o;
  logic [XLEN-1:0] inst_pc_o;
  logic [XLEN-1:0] pc_next_o;
  logic            pc_wr_en_i;
  logic [XLEN-1:0] alu_data_i;
  logic            fetch_misalign_o;

  modport master (
    output iram_rd_en_o, iram_rd_addr_o,
    input  iram_rd_valid_i, iram_rd_data_i,
    output inst_valid_o, inst_data_o, inst_pc_o, pc_next_o,
    input  inst_ready_i, pc_wr_en_i, alu_data_i,
    output fetch_misalign_o
  );

  modport slave (
    input  iram_rd_en_o, iram_rd_addr_o,
    output iram_rd_valid_i, iram_rd_data_i,
    input  inst_valid_o, inst_data_o, inst_pc_o, pc_next_o,
    output inst_ready_i, pc_wr_en_i, alu_data_i,
    input  fetch_misalign_o
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues IRAM word reads and buffers {pc, inst} pairs.
// Optional macro IFU_MISALIGN_EN: a redirect target with bit[1] set latches fetch_misalign_o and halts fetch.
module ifu #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  ifu_if.master bus
);

  localparam int unsigned     PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned     CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
`ifdef IFU_MISALIGN_EN
    , S_HALT = 2'd3
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [XLEN-1:0]  r_fifo_pc   [FIFO_DEPTH];
  logic [XLEN-1:0]  r_fifo_inst [FIFO_DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_redirect;
  logic             w_halted;
  logic             w_misalign_hit;
  logic [XLEN-1:0]  w_target;
  logic [CNT_W:0]   w_sum;
  logic             w_issue;
  logic             w_accept;
  logic             w_push;
  logic             w_drop;
  logic [CNT_W-1:0] w_drop_redir;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && bus.inst_ready_i;
  assign w_redirect = w_pop && bus.pc_wr_en_i;

`ifdef IFU_MISALIGN_EN
  logic r_misalign;

  assign w_target       = bus.alu_data_i & ~XLEN'(1);
  assign w_misalign_hit = w_redirect && w_target[1];
  assign w_halted       = (r_state == S_HALT);
`else
  assign w_target       = bus.alu_data_i & ~XLEN'(3);
  assign w_misalign_hit = 1'b0;
  assign w_halted       = 1'b0;
`endif

  // Reads in flight plus buffered entries never exceed the FIFO depth, so a push always has room.
  assign w_sum    = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_issue  = (r_state == S_RUN) && (w_sum < (CNT_W + 1)'(FIFO_DEPTH)) && !w_redirect;
  assign w_accept = bus.iram_rd_valid_i && (r_drop_cnt == '0) && !w_halted;
  assign w_push   = w_accept && !w_redirect;
  assign w_drop   = bus.iram_rd_valid_i && (r_drop_cnt != '0);

  // Every read still in flight after the redirect edge becomes a stale response to discard.
  assign w_drop_redir = r_drop_cnt + r_outstanding - CNT_W'(bus.iram_rd_valid_i);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN, S_FLUSH: begin
        if (w_redirect) begin
          w_state_nxt = (w_drop_redir != '0) ? S_FLUSH : S_RUN;
        end else if ((r_state == S_FLUSH) &&
                     ((r_drop_cnt == '0) || ((r_drop_cnt == CNT_W'(1)) && bus.iram_rd_valid_i))) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = r_state;
    endcase
`ifdef IFU_MISALIGN_EN
    if (w_misalign_hit) begin
      w_state_nxt = S_HALT;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (w_redirect) begin
      r_fetch_pc    <= w_target;
      r_resp_pc     <= w_target;
      r_outstanding <= '0;
      r_drop_cnt    <= w_drop_redir;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + XLEN'(4);
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_accept);
    end
  end

  // FIFO control; a redirect empties it and overrides any same-cycle push.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
      r_fifo_inst[r_wr_ptr] <= bus.iram_rd_data_i;
    end
  end

`ifdef IFU_MISALIGN_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_misalign <= 1'b0;
    end else if (w_misalign_hit) begin
      r_misalign <= 1'b1;
    end
  end

  assign bus.fetch_misalign_o = r_misalign;
`else
  assign bus.fetch_misalign_o = 1'b0;
`endif

  assign bus.iram_rd_en_o   = w_issue;
  assign bus.iram_rd_addr_o = r_fetch_pc;
  assign bus.inst_valid_o   = w_valid;
  assign bus.inst_data_o    = w_valid ? r_fifo_inst[r_rd_ptr] : NOP;
  assign bus.inst_pc_o      = w_valid ? r_fifo_pc[r_rd_ptr] : '0;
  assign bus.pc_next_o      = w_valid ? (r_fifo_pc[r_rd_ptr] + XLEN'(4)) : '0;

endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu: random-latency IRAM model plus a queue-based fetch/prefetch reference model.
// Build with +define+IFU_MISALIGN_EN to exercise the misaligned-target halt behaviour.
module tb_ifu;
  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_if #(.XLEN(XLEN)) bus ();

  ifu #(.XLEN(XLEN), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        q_req[$];   // reads issued, not yet answered by the RAM
  logic [31:0] q_fifo[$];  // pcs expected in the prefetch buffer, head first
  logic [31:0] exp_fetch;
  bit          boot, halted, exp_mis;
  int          cyc;
  int          lat_min = 1, lat_max = 1;
  int          n_checks = 0, n_pass = 0;
  logic        drv_ready, drv_wr;
  logic [31:0] drv_alu;
  logic        obs_en, obs_valid;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.iram_rd_valid_i = 1'b0;
    bus.iram_rd_data_i  = '0;
    bus.inst_ready_i    = 1'b0;
    bus.pc_wr_en_i      = 1'b0;
    bus.alu_data_i      = '0;
    drv_ready = 1'b0; drv_wr = 1'b0; drv_alu = '0;
    repeat (2) @(posedge clk);
    #1;
    q_req.delete();
    q_fifo.delete();
    exp_fetch = RST_PC; boot = 1'b1; halted = 1'b0; exp_mis = 1'b0; cyc = 0;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic tick();
    bit          resp, pop, redir, exp_en;
    int          live, stale;
    req_t        e, n;
    logic [31:0] tgt, hp;
    resp = (q_req.size() > 0) && (q_req[0].due <= cyc);
    bus.iram_rd_valid_i = resp;
    bus.iram_rd_data_i  = resp ? mem_word(q_req[0].addr) : $urandom;
    bus.inst_ready_i    = drv_ready;
    bus.pc_wr_en_i      = drv_wr;
    bus.alu_data_i      = drv_alu;
    #2;
    live = 0; stale = 0;
    foreach (q_req[i]) if (q_req[i].stale) stale++; else live++;
    pop    = (q_fifo.size() > 0) && drv_ready;
    redir  = pop && drv_wr;
    exp_en = !boot && !halted && (stale == 0) && (live + q_fifo.size() < DEPTH) && !redir;

    n_checks++;
    if (bus.iram_rd_en_o !== exp_en)
      $display("FAIL rd_en cyc=%0d got %b want %b", cyc, bus.iram_rd_en_o, exp_en);
    else n_pass++;
    if (exp_en) begin
      n_checks++;
      if (bus.iram_rd_addr_o !== exp_fetch)
        $display("FAIL rd_addr cyc=%0d got %h want %h", cyc, bus.iram_rd_addr_o, exp_fetch);
      else n_pass++;
    end
    n_checks++;
    if (bus.inst_valid_o !== (q_fifo.size() > 0))
      $display("FAIL inst_valid cyc=%0d got %b want %b", cyc, bus.inst_valid_o, q_fifo.size() > 0);
    else n_pass++;
    if (q_fifo.size() > 0) begin
      hp = q_fifo[0];
      n_checks++;
      if (bus.inst_pc_o !== hp) $display("FAIL inst_pc cyc=%0d got %h want %h", cyc, bus.inst_pc_o, hp);
      else n_pass++;
      n_checks++;
      if (bus.inst_data_o !== mem_word(hp))
        $display("FAIL inst_data cyc=%0d got %h want %h", cyc, bus.inst_data_o, mem_word(hp));
      else n_pass++;
      n_checks++;
      if (bus.pc_next_o !== hp + 32'd4)
        $display("FAIL pc_next cyc=%0d got %h want %h", cyc, bus.pc_next_o, hp + 32'd4);
      else n_pass++;
    end else begin
      n_checks++;
      if (bus.inst_data_o !== NOP) $display("FAIL nop_idle cyc=%0d got %h want %h", cyc, bus.inst_data_o, NOP);
      else n_pass++;
    end
    n_checks++;
    if (bus.fetch_misalign_o !== exp_mis)
      $display("FAIL misalign cyc=%0d got %b want %b", cyc, bus.fetch_misalign_o, exp_mis);
    else n_pass++;

    obs_en = bus.iram_rd_en_o; obs_addr = bus.iram_rd_addr_o;
    obs_valid = bus.inst_valid_o; obs_pc = bus.inst_pc_o;

    if (resp) e = q_req.pop_front();
    if (pop) void'(q_fifo.pop_front());
    if (resp && !e.stale && !redir && !halted) q_fifo.push_back(e.addr);
    if (redir) begin
      q_fifo.delete();
      foreach (q_req[i]) q_req[i].stale = 1'b1;
`ifdef IFU_MISALIGN_EN
      tgt = drv_alu & ~32'h1;
      if (tgt[1]) begin halted = 1'b1; exp_mis = 1'b1; end
`else
      tgt = drv_alu & ~32'h3;
`endif
      exp_fetch = tgt;
    end
    if (exp_en) begin
      n.addr = exp_fetch; n.due = cyc + $urandom_range(lat_max, lat_min); n.stale = 1'b0;
      q_req.push_back(n);
      exp_fetch = exp_fetch + 32'd4;
    end
    boot = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for a buffered instruction, then pops it with a redirect to tgt.
  task automatic redirect_to(input logic [31:0] tgt);
    int k;
    drv_ready = 1'b0; drv_wr = 1'b0;
    for (k = 0; k < 40 && q_fifo.size() == 0; k++) tick();
    n_checks++;
    if (q_fifo.size() == 0) $display("FAIL redirect_wait timeout got empty want head");
    else n_pass++;
    drv_ready = 1'b1; drv_wr = 1'b1; drv_alu = tgt;
    tick();
    drv_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    tick();
    n_checks++;
    if (obs_en !== 1'b1 || obs_addr !== RST_PC)
      $display("FAIL first_req got en=%b addr=%h want en=1 addr=%h", obs_en, obs_addr, RST_PC);
    else n_pass++;
    drv_ready = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.iram_rd_en_o !== 1'b0 || bus.inst_valid_o !== 1'b0 || bus.fetch_misalign_o !== 1'b0)
      $display("FAIL async_reset_ctl got en=%b valid=%b mis=%b want 0 0 0",
               bus.iram_rd_en_o, bus.inst_valid_o, bus.fetch_misalign_o);
    else n_pass++;
    n_checks++;
    if (bus.iram_rd_addr_o !== RST_PC || bus.inst_data_o !== NOP)
      $display("FAIL async_reset_data got addr=%h data=%h want %h %h", bus.iram_rd_addr_o, bus.inst_data_o, RST_PC, NOP);
    else n_pass++;
    n_checks++;
    if (bus.inst_pc_o !== 32'h0 || bus.pc_next_o !== 32'h0)
      $display("FAIL async_reset_pc got pc=%h next=%h want 0 0", bus.inst_pc_o, bus.pc_next_o);
    else n_pass++;
  endtask

  task automatic test_stream();
    int bubbles = 0;
    do_reset();
    lat_min = 1; lat_max = 1;
    drv_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i >= 3 && !obs_valid) bubbles++;
    end
    n_checks++;
    if (bubbles != 0) $display("FAIL stream_bubbles got %0d want 0", bubbles);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int iss = 0;
    do_reset();
    lat_min = 1; lat_max = 1;
    drv_ready = 1'b0;
    repeat (10) begin
      tick();
      if (obs_en) iss++;
    end
    n_checks++;
    if (iss != DEPTH) $display("FAIL stall_issue_count got %0d want %0d", iss, DEPTH);
    else n_pass++;
    drv_ready = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_redirect_stale();
    bit found = 1'b0;
    do_reset();
    lat_min = 2; lat_max = 2;
    drv_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (q_fifo.size() > 0 && q_fifo[0] == 32'h8) break;
      tick();
    end
    drv_wr = 1'b1; drv_alu = 32'h100;
    tick();
    drv_wr = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (obs_valid && obs_pc == 32'h100) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL stale_target_head got none want pc 00000100");
    else n_pass++;
  endtask

  task automatic test_redirect_full();
    bit hit = 1'b0;
    do_reset();
    lat_min = 3; lat_max = 3;
    drv_ready = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (q_fifo.size() == DEPTH - 1 && q_req.size() > 0 && q_req[0].due <= cyc) hit = 1'b1;
      else tick();
    end
    n_checks++;
    if (!hit) $display("FAIL full_setup timeout got %0d entries want %0d", q_fifo.size(), DEPTH - 1);
    else n_pass++;
    drv_ready = 1'b1; drv_wr = 1'b1; drv_alu = 32'h200;
    tick();
    drv_wr = 1'b0; drv_ready = 1'b0;
    tick();
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL full_redirect_empty got valid=%b want 0", obs_valid);
    else n_pass++;
    n_checks++;
    if (obs_en !== 1'b1 || obs_addr !== 32'h200)
      $display("FAIL full_redirect_req got en=%b addr=%h want en=1 addr=00000200", obs_en, obs_addr);
    else n_pass++;
    repeat (10) tick();
  endtask

  task automatic test_wrap();
    bit saw_hi = 1'b0, wrapped = 1'b0;
    do_reset();
    lat_min = 1; lat_max = 2;
    redirect_to(32'hFFFF_FFF8);
    drv_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (obs_en) begin
        if (saw_hi && obs_addr == 32'h0) wrapped = 1'b1;
        saw_hi = (obs_addr == 32'hFFFF_FFFC);
      end
    end
    n_checks++;
    if (!wrapped) $display("FAIL pc_wrap got no 00000000 after fffffffc want wrap");
    else n_pass++;
  endtask

  task automatic test_misalign();
    int en_cnt = 0, val_cnt = 0;
    bit got = 1'b0;
    do_reset();
    lat_min = 1; lat_max = 2;
    drv_ready = 1'b1;
    repeat (6) tick();
    redirect_to(32'h102);
    drv_ready = 1'b1;
`ifdef IFU_MISALIGN_EN
    repeat (10) begin
      tick();
      if (obs_en) en_cnt++;
      if (obs_valid) val_cnt++;
    end
    n_checks++;
    if (en_cnt != 0 || val_cnt != 0)
      $display("FAIL halt_quiet got req=%0d valid=%0d want 0 0", en_cnt, val_cnt);
    else n_pass++;
    n_checks++;
    if (bus.fetch_misalign_o !== 1'b1) $display("FAIL misalign_flag got %b want 1", bus.fetch_misalign_o);
    else n_pass++;
`else
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (obs_en) begin
        got = 1'b1;
        n_checks++;
        if (obs_addr !== 32'h100) $display("FAIL misalign_resume got %h want 00000100", obs_addr);
        else n_pass++;
      end
    end
    n_checks++;
    if (!got || bus.fetch_misalign_o !== 1'b0)
      $display("FAIL misalign_off got req=%b flag=%b want req=1 flag=0", got, bus.fetch_misalign_o);
    else n_pass++;
    repeat (10) tick();
`endif
  endtask

  task automatic test_random();
    int pops = 0, redirs = 0;
    logic [31:0] a;
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 800; k++) begin
      drv_ready = ($urandom_range(99, 0) < 70);
      drv_wr    = ($urandom_range(99, 0) < 10);
      a = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : ($urandom & 32'h0000_0FFF);
`ifdef IFU_MISALIGN_EN
      a = a & ~32'h2;
`endif
      drv_alu = a;
      if (q_fifo.size() > 0 && drv_ready) begin
        pops++;
        if (drv_wr) redirs++;
      end
      tick();
    end
    drv_wr = 1'b0;
    n_checks++;
    if (pops < 100 || redirs == 0) $display("FAIL random_progress got pops=%0d redirs=%0d want >=100 >0", pops, redirs);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_full();
    test_wrap();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
